// File: rtl/imem_loader.sv
// Packs debug-UART bytes (big-endian) into words and writes them to instruction memory at 0,4,8,...
// Each word: 1 setup cycle, 1 write-strobe cycle, 1 check cycle; bytes arriving meanwhile are dropped and flagged.
module imem_loader #(
    parameter int                   INST_BITS = 32,
    parameter int                   CELLS     = 256,
    parameter logic [INST_BITS-1:0] HALT_INST = 32'hFFFF_FFFF
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic                     i_rx_valid,
    input  logic [7:0]               i_rx_data,
    output logic [INST_BITS-1:0]     o_dbg_addr,
    output logic [INST_BITS-1:0]     o_dbg_inst,
    output logic                     o_dbg_wr_en,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_full,
    output logic                     o_err,
    output logic [$clog2(CELLS)-1:0] o_inst_count
);

    localparam int                   CNT_W     = $clog2(CELLS);
    localparam logic [INST_BITS-1:0] LAST_ADDR = INST_BITS'(CELLS - 4);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        SETUP = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           byte_cnt_q, byte_cnt_d;
    logic [INST_BITS-1:0] shift_q, shift_d;
    logic [INST_BITS-1:0] addr_q, addr_d;
    logic [INST_BITS-1:0] inst_q, inst_d;
    logic                 wr_en_q, wr_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 full_q, full_d;
    logic                 err_q, err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            inst_q     <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            inst_q     <= inst_d;
            wr_en_q    <= wr_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            full_q     <= full_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        wr_en_d    = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;
        full_d     = full_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                // A byte coinciding with start is discarded silently.
                if (i_start) begin
                    state_d    = RECV;
                    addr_d     = '0;
                    cnt_d      = '0;
                    full_d     = 1'b0;
                    err_d      = 1'b0;
                    done_d     = 1'b0;
                    byte_cnt_d = '0;
                    busy_d     = 1'b1;
                end
            end
            RECV: begin
                if (i_rx_valid) begin
                    shift_d = {shift_q[INST_BITS-9:0], i_rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        inst_d     = shift_d;
                        state_d    = SETUP;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            SETUP: begin
                if (i_rx_valid) err_d = 1'b1;
                wr_en_d = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                if (i_rx_valid) err_d = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = CHECK;
            end
            CHECK: begin
                if (i_rx_valid) err_d = 1'b1;
                // HALT wins over the full condition when it lands in the last slot.
                if (inst_q == HALT_INST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    full_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    addr_d  = addr_q + INST_BITS'(4);
                    state_d = RECV;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign o_dbg_addr   = addr_q;
    assign o_dbg_inst   = inst_q;
    assign o_dbg_wr_en  = wr_en_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_full       = full_q;
    assign o_err        = err_q;
    assign o_inst_count = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write log captured at the falling edge, compared against hand-computed words.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_inst;
    logic        dbg_wr_en;
    logic        busy;
    logic        done;
    logic        full;
    logic        err;
    logic [7:0]  inst_count;

    imem_loader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_dbg_addr   (dbg_addr),
        .o_dbg_inst   (dbg_inst),
        .o_dbg_wr_en  (dbg_wr_en),
        .o_busy       (busy),
        .o_done       (done),
        .o_full       (full),
        .o_err        (err),
        .o_inst_count (inst_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    always @(negedge clk) begin
        if (dbg_wr_en) begin
            wa.push_back(dbg_addr);
            wd.push_back(dbg_inst);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a, input logic [31:0] d);
        if (idx < wa.size()) begin
            chk({tag, "_addr"}, wa[idx], a);
            chk({tag, "_inst"}, wd[idx], d);
        end else begin
            chk({tag, "_missing"}, wa.size(), idx + 1);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Trailing wait lets the SETUP/WRITE/CHECK sequence finish before the next byte.
    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
        repeat (3) @(negedge clk);
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int k = 0; k < 200 && !done; k++) @(negedge clk);
        if (!done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_addr"},  dbg_addr, 32'd0);
        chk({tag, "_inst"},  dbg_inst, 32'd0);
        chk({tag, "_wr_en"}, dbg_wr_en, 32'd0);
        chk({tag, "_busy"},  busy, 32'd0);
        chk({tag, "_done"},  done, 32'd0);
        chk({tag, "_full"},  full, 32'd0);
        chk({tag, "_err"},   err, 32'd0);
        chk({tag, "_count"}, inst_count, 32'd0);
    endtask

    initial begin
        int bad;
        logic [31:0] w;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;

        // Bytes in IDLE are ignored without a flag.
        send_byte(8'h42);
        chk("idle_byte_err", err, 32'd0);
        chk("idle_byte_busy", busy, 32'd0);

        // Basic load with cycle-accurate look at the first word.
        start_pulse();
        chk("t1_busy", busy, 32'd1);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h78;
        @(negedge clk); rx_valid = 1'b0;
        chk("tp1_inst", dbg_inst, 32'h12345678);
        chk("tp1_wr",   dbg_wr_en, 32'd0);
        chk("tp1_addr", dbg_addr, 32'd0);
        @(negedge clk);
        chk("tp2_wr",   dbg_wr_en, 32'd1);
        chk("tp2_inst", dbg_inst, 32'h12345678);
        chk("tp2_addr", dbg_addr, 32'd0);
        @(negedge clk);
        chk("tp3_wr",   dbg_wr_en, 32'd0);
        chk("tp3_addr", dbg_addr, 32'd0);
        chk("tp3_count", inst_count, 32'd1);
        @(negedge clk);
        chk("tp4_addr", dbg_addr, 32'd4);
        send_word(32'hFFFFFFFF);
        wait_done("t1");
        chk("t1_nwr", wa.size(), 32'd2);
        chk_wr("t1_w0", 0, 32'd0, 32'h12345678);
        chk_wr("t1_w1", 1, 32'd4, 32'hFFFFFFFF);
        chk("t1_done", done, 32'd1);
        chk("t1_busy_end", busy, 32'd0);
        chk("t1_count", inst_count, 32'd2);
        chk("t1_full", full, 32'd0);

        // Fill all 64 slots without HALT.
        wa.delete(); wd.delete();
        start_pulse();
        chk("full_done_clr", done, 32'd0);
        for (int i = 0; i < 64; i++) send_word({8'(i), 8'hA5, 8'h5A, 8'(i)});
        wait_done("full");
        repeat (10) @(negedge clk);
        chk("full_nwr", wa.size(), 32'd64);
        bad = 0;
        for (int i = 0; i < 64 && i < wa.size(); i++) begin
            w = {8'(i), 8'hA5, 8'h5A, 8'(i)};
            if (wa[i] !== 32'(4 * i) || wd[i] !== w) bad++;
        end
        chk("full_seq_bad", bad, 32'd0);
        chk_wr("full_last", 63, 32'd252, {8'd63, 8'hA5, 8'h5A, 8'd63});
        chk("full_flag", full, 32'd1);
        chk("full_count", inst_count, 32'd64);
        chk("full_done", done, 32'd1);
        chk("full_err", err, 32'd0);

        // HALT in the last slot: HALT wins, no full flag.
        wa.delete(); wd.delete();
        start_pulse();
        chk("hlast_full_clr", full, 32'd0);
        for (int i = 0; i < 63; i++) send_word({8'h3C, 8'(i), 8'h00, 8'h11});
        send_word(32'hFFFFFFFF);
        wait_done("hlast");
        chk("hlast_nwr", wa.size(), 32'd64);
        chk_wr("hlast_w63", 63, 32'd252, 32'hFFFFFFFF);
        chk("hlast_full", full, 32'd0);
        chk("hlast_count", inst_count, 32'd64);

        // A byte during WRITE is dropped and flagged; the load carries on.
        wa.delete(); wd.delete();
        start_pulse();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h99;
        @(negedge clk); rx_valid = 1'b0;
        @(negedge clk);
        send_word(32'h55667788);
        send_word(32'hFFFFFFFF);
        wait_done("err");
        chk("err_flag", err, 32'd1);
        chk("err_nwr", wa.size(), 32'd3);
        chk_wr("err_w0", 0, 32'd0, 32'h11223344);
        chk_wr("err_w1", 1, 32'd4, 32'h55667788);
        chk_wr("err_w2", 2, 32'd8, 32'hFFFFFFFF);
        chk("err_count", inst_count, 32'd3);
        start_pulse();
        chk("err_cleared", err, 32'd0);
        chk("err_restart_busy", busy, 32'd1);

        // Reset during the WRITE cycle.
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        @(negedge clk);
        chk("rst_pre_wr", dbg_wr_en, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("rst_mid");
        rst = 1'b0;
        wa.delete(); wd.delete();

        // Start with a simultaneous byte: start taken, byte dropped, no error.
        @(negedge clk);
        start = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        send_word(32'hAABBCCDD);
        send_word(32'hFFFFFFFF);
        wait_done("post_rst");
        chk("post_rst_err", err, 32'd0);
        chk_wr("post_rst_w0", 0, 32'd0, 32'hAABBCCDD);
        chk_wr("post_rst_w1", 1, 32'd4, 32'hFFFFFFFF);

        // Restart from DONE.
        wa.delete(); wd.delete();
        start_pulse();
        chk("again_done_low", done, 32'd0);
        chk("again_addr", dbg_addr, 32'd0);
        send_word(32'h01020304);
        chk("again_mid_done", done, 32'd0);
        send_word(32'hFFFFFFFF);
        wait_done("again");
        chk_wr("again_w0", 0, 32'd0, 32'h01020304);
        chk_wr("again_w1", 1, 32'd4, 32'hFFFFFFFF);
        chk("again_count", inst_count, 32'd2);
        chk("again_done", done, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
